// File: rtl/alu_arbiter_pkg.sv
// Shared core definitions: ALU opcodes, the opcode type and the arbiter FSM states.
package core_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_AND = 4'h0;
   localparam alu_op_t ALU_OR  = 4'h1;
   localparam alu_op_t ALU_ADD = 4'h2;
   localparam alu_op_t ALU_SUB = 4'h3;
   localparam alu_op_t ALU_EQ  = 4'h4;

   localparam int DATA_W = 32;
   localparam int ERR_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } arb_state_t;

   function automatic logic is_alu_op(input alu_op_t op);
      return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
             (op == ALU_SUB) || (op == ALU_EQ);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters plus one consumer and the arbiter.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   import core_pkg::*;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   alu_op_t [NUM_REQ-1:0]          req_op;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_b;

   logic                           rsp_valid;
   logic                           rsp_ready;
   logic [ID_W-1:0]                rsp_id;
   logic [DATA_W-1:0]              rsp_result;
   logic                           rsp_zero;
   logic                           rsp_err;
   logic [ERR_W-1:0]               err_count;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, err_count
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, err_count
   );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined opcodes flag unknown_op and return zero.
module alu
   import core_pkg::*;
(
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              unknown_op
);

   always_comb begin
      result     = '0;
      unknown_op = 1'b0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_EQ:  result = {{(DATA_W-1){1'b0}}, (a == b)};
         default: unknown_op = 1'b1;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               any
);

   logic [NUM_REQ-1:0][ID_W-1:0] cand_id;
   logic [NUM_REQ-1:0]           cand_req;

   // cand_id[k] is the requester sitting k places after ptr in the rotation
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
      assign cand_id[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ?
                            ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
      assign cand_req[gi] = req[cand_id[gi]];
   end

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any && cand_req[k]) begin
            any    = 1'b1;
            gnt_id = cand_id[k];
         end
      end
      if (any) begin
         gnt[gnt_id] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among NUM_REQ requesters: round-robin grant, one op in flight,
// tagged response held on the bus until the consumer accepts it.
module alu_arbiter
   import core_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic          clk,
   input  logic          reset_n,
   alu_arbiter_if.slave  bus
);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   alu_op_t           op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [ID_W-1:0]   id_q, id_d;

   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_err_q, rsp_err_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;

   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] req_ready;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;
   logic [ID_W-1:0]    gnt_id_next;

   logic [DATA_W-1:0]  alu_result;
   logic               alu_zero;
   logic               alu_unknown;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .any     (gnt_any)
   );

   alu u_alu (
      .op         (op_q),
      .a          (a_q),
      .b          (b_q),
      .result     (alu_result),
      .zero       (alu_zero),
      .unknown_op (alu_unknown)
   );

   assign gnt_id_next = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      err_count_d  = err_count_q;
      req_ready    = '0;

      case (state_q)
         S_IDLE: begin
            // grant stays low while reset is held so no requester sees a phantom handshake
            if (reset_n) begin
               req_ready = gnt;
            end
            if (gnt_any) begin
               op_d     = bus.req_op[gnt_id];
               a_d      = bus.req_a[gnt_id];
               b_d      = bus.req_b[gnt_id];
               id_d     = gnt_id;
               rr_ptr_d = gnt_id_next;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            if (alu_unknown) begin
               rsp_result_d = '0;
               rsp_zero_d   = 1'b1;
               rsp_err_d    = 1'b1;
               if (err_count_q != {ERR_W{1'b1}}) begin
                  err_count_d = err_count_q + ERR_W'(1);
               end
            end else begin
               rsp_result_d = alu_result;
               rsp_zero_d   = alu_zero;
               rsp_err_d    = 1'b0;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         op_q         <= ALU_AND;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses queued at each request handshake.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import core_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     result;
      logic            zero;
      logic            err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   model_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [ID_W-1:0] id, input alu_op_t op,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.id  = id;
      e.err = 1'b0;
      case (op)
         ALU_AND: e.result = a & b;
         ALU_OR:  e.result = a | b;
         ALU_ADD: e.result = a + b;
         ALU_SUB: e.result = a - b;
         ALU_EQ:  e.result = (a == b) ? 32'd1 : 32'd0;
         default: begin
            e.result = 32'd0;
            e.err    = 1'b1;
         end
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   // monitor: pop/compare accepted responses, push expectations on request handshakes
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
         model_err = 0;
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            $display("rsp id=%0d result=%08h zero=%0b err=%0b err_count=%0d",
                     bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err, bus.err_count);
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 64'(sb.size()), 64'd1);
            end else begin
               mon_e = sb.pop_front();
               chk("rsp_id", bus.rsp_id, mon_e.id);
               chk("rsp_result", bus.rsp_result, mon_e.result);
               chk("rsp_zero", bus.rsp_zero, mon_e.zero);
               chk("rsp_err", bus.rsp_err, mon_e.err);
               if (mon_e.err && model_err < 255) model_err++;
               chk("err_count", bus.err_count, 64'(model_err));
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               sb.push_back(model(ID_W'(i), bus.req_op[i], bus.req_a[i], bus.req_b[i]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid[i] = 1'b1;
      bus.req_op[i]    = op;
      bus.req_a[i]     = a;
      bus.req_b[i]     = b;
   endtask

   task automatic wait_ready(input int i);
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.req_ready[i]) begin
            ok = 1'b1;
            break;
         end
      end
      chk($sformatf("ready%0d_seen", i), 64'(ok), 64'd1);
   endtask

   task automatic wait_rsp();
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rsp_seen", 64'(ok), 64'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.rsp_valid) break;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // issue one op and return at the first negedge with rsp_valid high
   task automatic run_op(input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      tick();
      set_req(i, op, a, b);
      wait_ready(i);
      tick();
      bus.req_valid[i] = 1'b0;
      wait_rsp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     gid;
      bit     ok;
      int     cnt;
      longint t_last;

      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      reset_n       = 1'b0;
      t_last        = 0;

      // reset values, with a request pending that must not be granted
      bus.req_valid = 4'b0001;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 4'b0000);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_id", bus.rsp_id, 2'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
      chk("rst_err_count", bus.err_count, 8'd0);
      bus.req_valid = '0;
      tick();
      reset_n = 1'b1;

      // all four requesters continuously valid: grants 0,1,2,3,0 every 3 cycles
      tick();
      bus.rsp_ready = 1'b1;
      set_req(0, ALU_AND, $urandom, $urandom);
      set_req(1, ALU_OR,  $urandom, $urandom);
      set_req(2, ALU_ADD, $urandom, $urandom);
      set_req(3, ALU_SUB, $urandom, $urandom);
      for (int k = 0; k < 5; k++) begin
         ok  = 1'b0;
         gid = -1;
         for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
               ok = 1'b1;
               break;
            end
         end
         chk("t2_grant_seen", 64'(ok), 64'd1);
         for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gid = i;
         chk("t2_grant_order", 64'(gid), 64'(k % NUM_REQ));
         if (k > 0) chk("t2_spacing_ns", 64'($time - t_last), 64'd30);
         t_last = $time;
         tick();
         if (k == 4) begin
            bus.req_valid = '0;
         end else if (gid >= 0) begin
            bus.req_a[gid] = $urandom;
            bus.req_b[gid] = $urandom;
         end
      end
      drain();

      // single ADD with exact latency
      tick();
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      wait_ready(0);
      chk("t1_ready", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_lat_t1", bus.rsp_valid, 1'b0);
      @(negedge clk);
      chk("t1_lat_t2", bus.rsp_valid, 1'b1);
      chk("t1_id", bus.rsp_id, 2'd0);
      chk("t1_result", bus.rsp_result, 32'd12);
      chk("t1_zero", bus.rsp_zero, 1'b0);
      chk("t1_err", bus.rsp_err, 1'b0);
      drain();

      // backpressure: response held stable, no grant while req0 waits
      tick();
      bus.rsp_ready = 1'b0;
      run_op(2, ALU_SUB, 32'd3, 32'd3);
      tick();
      set_req(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_hold_valid", bus.rsp_valid, 1'b1);
         chk("t3_hold_id", bus.rsp_id, 2'd2);
         chk("t3_hold_result", bus.rsp_result, 32'd0);
         chk("t3_hold_zero", bus.rsp_zero, 1'b1);
         chk("t3_no_grant", bus.req_ready, 4'b0000);
      end
      tick();
      bus.rsp_ready = 1'b1;
      wait_ready(0);
      tick();
      bus.req_valid[0] = 1'b0;
      drain();

      // undefined opcode, then saturation of err_count
      run_op(1, 4'hF, 32'd9, 32'd9);
      chk("t4_err", bus.rsp_err, 1'b1);
      chk("t4_result", bus.rsp_result, 32'd0);
      chk("t4_zero", bus.rsp_zero, 1'b1);
      chk("t4_err_count", bus.err_count, 8'd1);
      for (int k = 0; k < 299; k++) begin
         run_op(1, alu_op_t'(5 + (k % 11)), $urandom, $urandom);
      end
      drain();
      chk("t4_err_sat", bus.err_count, 8'd255);

      // wrap and equality corners
      run_op(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
      chk("t5_add_wrap", bus.rsp_result, 32'd0);
      chk("t5_add_zero", bus.rsp_zero, 1'b1);
      run_op(3, ALU_EQ, 32'hA5A5_0000, 32'hA5A5_0000);
      chk("t5_eq_result", bus.rsp_result, 32'd1);
      chk("t5_eq_zero", bus.rsp_zero, 1'b0);
      drain();

      // reset during S_EXEC discards the op and rewinds rr_ptr
      tick();
      set_req(2, ALU_ADD, 32'd1, 32'd2);
      wait_ready(2);
      tick();
      bus.req_valid[2] = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("t6_rst_req_ready", bus.req_ready, 4'b0000);
      chk("t6_rst_err_count", bus.err_count, 8'd0);
      chk("t6_rst_result", bus.rsp_result, 32'd0);
      chk("t6_rst_id", bus.rsp_id, 2'd0);
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) cnt++;
      end
      chk("t6_no_rsp", 64'(cnt), 64'd0);
      tick();
      set_req(0, ALU_ADD, 32'd10, 32'd20);
      set_req(3, ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
      @(negedge clk);
      chk("t6_req0_wins", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid[0] = 1'b0;
      wait_ready(3);
      tick();
      bus.req_valid[3] = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
